// File: rtl/sa_req_pkg.sv
// Shared constants, FSM state type and the element requantizer for the
// systolic-array output requantizer. Optional build macro: SA_REQ_ROUND_EN
// (round half up before the shift; otherwise the shift truncates toward -inf).
package sa_req_pkg;

   localparam int ELEM_W     = 8;
   localparam int IN_W       = 64;
   localparam int ROW_LEN    = 8;
   localparam int FIFO_DEPTH = 8;
   localparam int MAX_T      = 8;
   localparam int ENTRY_W    = IN_W + 1;   // {last, packed row}

   typedef enum logic {IDLE, COLLECT} state_t;

   // Arithmetic right shift at IN_W+1 bits, so the rounding add cannot wrap,
   // then saturate to the int8 range.
   function automatic logic [ELEM_W-1:0] requant(input logic [IN_W-1:0] x,
                                                 input logic [5:0]      sh);
      logic signed [IN_W:0] v;
      logic signed [IN_W:0] rnd;
      v   = signed'({x[IN_W-1], x});
      rnd = '0;
`ifdef SA_REQ_ROUND_EN
      if (sh != 6'd0) rnd = signed'({{IN_W{1'b0}}, 1'b1} << (sh - 6'd1));
`endif
      v = v + rnd;
      v = v >>> sh;
      if (v > 65'sd127)       return 8'h7f;
      else if (v < -65'sd128) return 8'h80;
      else                    return v[ELEM_W-1:0];
   endfunction

endpackage

// File: rtl/sa_out_requant_if.sv
// Element input / packed-row output bundle of the requantizer.
// slave = the requantizer, master = the driver/consumer side.
interface sa_out_requant_if;
   import sa_req_pkg::*;

   logic            in_valid;
   logic [IN_W-1:0] in_data;
   logic [3:0]      T;
   logic [5:0]      shift;
   logic            out_ready;
   logic            out_valid;
   logic [IN_W-1:0] out_data;
   logic            out_last;
   logic            ovf;
   logic            err;

   modport slave  (input  in_valid, in_data, T, shift, out_ready,
                   output out_valid, out_data, out_last, ovf, err);
   modport master (output in_valid, in_data, T, shift, out_ready,
                   input  out_valid, out_data, out_last, ovf, err);
endinterface

// File: rtl/sa_req_fifo.sv
// Row FIFO: FIFO_DEPTH entries of {last,row}, simultaneous push/pop,
// push accepted when full only if a pop happens in the same cycle.
module sa_req_fifo
   import sa_req_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] pop_data,
   output logic               full,
   output logic               empty
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               do_push, do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   // Gate the head so the output reads zero whenever nothing is buffered.
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards everything buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care until a pointer covers them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/sa_out_requant.sv
// Requantizes the SA output stream (64-bit signed -> int8), packs 8 elements
// per row and buffers rows in a FIFO toward the consumer.
// Optional build macro: SA_REQ_ROUND_EN (see sa_req_pkg::requant).
module sa_out_requant
   import sa_req_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   sa_out_requant_if.slave  io
);
   state_t             state;
   logic [3:0]         t_lat;
   logic [5:0]         sh_lat;
   logic [2:0]         col, row;
   logic [IN_W-1:0]    pack;
   logic               ovf_q, err_q;

   logic [3:0]         t_norm, t_eff;
   logic [5:0]         sh_eff;
   logic [ELEM_W-1:0]  q;
   logic               last_row, push, pop, full, empty;
   logic [ENTRY_W-1:0] push_data, pop_data;

   // Frame parameters come straight from the ports on the starting element,
   // from the latched copies for the rest of the frame.
   always_comb begin
      t_norm    = (io.T == 4'd0 || io.T > 4'(MAX_T)) ? 4'(MAX_T) : io.T;
      t_eff     = (state == IDLE) ? t_norm   : t_lat;
      sh_eff    = (state == IDLE) ? io.shift : sh_lat;
      q         = requant(io.in_data, sh_eff);
      last_row  = ({1'b0, row} == t_eff - 4'd1);
      push      = (state == COLLECT) && io.in_valid && (col == 3'(ROW_LEN-1));
      push_data = {last_row, q, pack[IN_W-ELEM_W-1:0]};
      pop       = io.out_valid && io.out_ready;
   end

   // Frame FSM, packing register and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         t_lat  <= 4'(MAX_T);
         sh_lat <= '0;
         col    <= '0;
         row    <= '0;
         pack   <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (push && full && !pop) ovf_q <= 1'b1;
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  t_lat          <= t_norm;
                  sh_lat         <= io.shift;
                  pack[ELEM_W-1:0] <= q;
                  col            <= 3'd1;
                  row            <= '0;
                  state          <= COLLECT;
               end
            end
            COLLECT: begin
               if (!io.in_valid) begin
                  // Abort: the partial row is dropped, completed rows stay queued.
                  err_q <= 1'b1;
                  col   <= '0;
                  row   <= '0;
                  pack  <= '0;
                  state <= IDLE;
               end else begin
                  pack[{col, 3'b000} +: ELEM_W] <= q;
                  if (col == 3'(ROW_LEN-1)) begin
                     col <= '0;
                     row <= row + 3'd1;
                     if (last_row) begin
                        row   <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sa_req_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty)
   );

   assign io.out_valid = !empty;
   assign io.out_data  = pop_data[IN_W-1:0];
   assign io.out_last  = pop_data[IN_W];
   assign io.ovf       = ovf_q;
   assign io.err       = err_q;
endmodule

// File: tb/tb_sa_out_requant.sv
// Scoreboard bench for sa_out_requant: the driver computes expected rows from
// a division-based requant model and queues them; a monitor pops and compares
// on every accepted output row.
module tb_sa_out_requant;
   import sa_req_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sa_out_requant_if bus();

   sa_out_requant dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   logic [64:0] sb[$];
   logic [63:0] elq[$];
   logic [64:0] last_rx;
   int          rx_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   bit          rnd_ready = 0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Floor(x / 2^sh) (optionally after adding half), clamped to int8.
   function automatic logic [7:0] ref_q(input logic signed [63:0] x, input int sh);
      logic signed [127:0] v, d, qq;
      v = x;
      d = 1;
      d = d << sh;
`ifdef SA_REQ_ROUND_EN
      if (sh > 0) v = v + d / 2;
`endif
      qq = v / d;
      if ((v % d) != 0 && v < 0) qq = qq - 1;
      if (qq > 127)  return 8'h7f;
      if (qq < -128) return 8'h80;
      return qq[7:0];
   endfunction

   function automatic logic [63:0] gen_elem();
      logic [63:0] e;
      if (elq.size() != 0) return elq.pop_front();
      case ($urandom % 4)
         0: e = 64'($signed($urandom_range(600)) - 300);
         1: e = {{48{1'b0}}, 16'($urandom)} - 64'd32768;
         2: e = {$urandom, $urandom};
         default: e = ($urandom % 2) ? 64'h7fff_ffff_ffff_ffff : 64'h8000_0000_0000_0000;
      endcase
      return e;
   endfunction

   // Sends n_send elements of a frame (n_send<0: full frame); in_valid is left high.
   task automatic send_frame(input int t, input int sh, input int n_send, input bit drop);
      int          teff;
      logic [7:0]  rowb[8];
      logic [63:0] w, e;
      teff = (t == 0 || t > 8) ? 8 : t;
      if (n_send < 0 || n_send > teff * 8) n_send = teff * 8;
      for (int i = 0; i < n_send; i++) begin
         @(posedge clk); #1;
         e = gen_elem();
         bus.in_valid = 1'b1;
         bus.in_data  = e;
         if (i == 0) begin
            bus.T = 4'(t); bus.shift = 6'(sh);
         end else begin
            bus.T = 4'($urandom); bus.shift = 6'($urandom);
         end
         if (rnd_ready) bus.out_ready = ($urandom % 4) != 0;
         rowb[i % 8] = ref_q(e, sh);
         if (i % 8 == 7 && !drop) begin
            for (int k = 0; k < 8; k++) w[k*8 +: 8] = rowb[k];
            sb.push_back({(i / 8 == teff - 1), w});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int k = 0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      #1 chk("drain_empty", 65'(sb.size()), 65'd0);
   endtask

   // Monitor: every accepted row must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_row actual=%h expected=none", {bus.out_last, bus.out_data});
         end else begin
            chk("row", {bus.out_last, bus.out_data}, sb.pop_front());
         end
         last_rx = {bus.out_last, bus.out_data};
         rx_cnt++;
      end
   end

   initial begin
      int rx0;
      bus.in_valid = 0; bus.in_data = '0; bus.T = '0; bus.shift = '0; bus.out_ready = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
      chk("rst_out_data",  65'(bus.out_data),  65'd0);
      chk("rst_out_last",  65'(bus.out_last),  65'd0);
      chk("rst_ovf",       65'(bus.ovf),       65'd0);
      chk("rst_err",       65'(bus.err),       65'd0);
      rst_n = 1'b1;

      // Basic row: 0..7, latency and packing order.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) elq.push_back(64'(i));
      send_frame(1, 0, -1, 0);
      @(negedge clk);
      chk("lat_before", 65'(bus.out_valid), 65'd0);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_after", 65'(bus.out_valid), 65'd1);
      chk("basic_word", {bus.out_last, bus.out_data}, {1'b1, 64'h0706050403020100});
      drain();

      // Rounding vs truncation at shift 4.
      elq.push_back(64'd40); elq.push_back(-64'd40);
      for (int i = 0; i < 6; i++) elq.push_back(64'd0);
      send_frame(1, 4, -1, 0);
      idle(1); drain();
`ifdef SA_REQ_ROUND_EN
      chk("shift4_pos", 65'(last_rx[7:0]),  65'h03);
      chk("shift4_neg", 65'(last_rx[15:8]), 65'hfe);
`else
      chk("shift4_pos", 65'(last_rx[7:0]),  65'h02);
      chk("shift4_neg", 65'(last_rx[15:8]), 65'hfd);
`endif

      // Saturation.
      elq.push_back(64'd1000); elq.push_back(-64'd1000);
      for (int i = 0; i < 6; i++) elq.push_back(64'd5);
      send_frame(1, 0, -1, 0);
      idle(1); drain();
      chk("sat_pos", 65'(last_rx[7:0]),  65'h7f);
      chk("sat_neg", 65'(last_rx[15:8]), 65'h80);

      // Fill the FIFO, then overflow with one more row.
      bus.out_ready = 1'b0;
      rx0 = rx_cnt;
      send_frame(8, 3, -1, 0);
      idle(2);
      chk("full_ovf0", 65'(bus.ovf), 65'd0);
      chk("full_valid", 65'(bus.out_valid), 65'd1);
      send_frame(1, 3, -1, 1);
      idle(2);
      chk("ovf_set", 65'(bus.ovf), 65'd1);
      drain();
      chk("full_rows", 65'(rx_cnt - rx0), 65'd8);

      // Abort after 13 elements of a T=4 frame.
      rx0 = rx_cnt;
      send_frame(4, 2, 13, 0);
      idle(3); drain();
      chk("abort_rows", 65'(rx_cnt - rx0), 65'd1);
      chk("abort_last", 65'(last_rx[64]), 65'd0);
      chk("abort_err", 65'(bus.err), 65'd1);
      rx0 = rx_cnt;
      send_frame(2, 1, -1, 0);
      idle(1); drain();
      chk("post_abort_rows", 65'(rx_cnt - rx0), 65'd2);
      chk("post_abort_last", 65'(last_rx[64]), 65'd1);

      // Reset mid-frame with 3 rows buffered.
      bus.out_ready = 1'b0;
      send_frame(8, 0, 28, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("midrst_valid", 65'(bus.out_valid), 65'd0);
      chk("midrst_ovf", 65'(bus.ovf), 65'd0);
      chk("midrst_err", 65'(bus.err), 65'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      rx0 = rx_cnt;
      send_frame(1, 5, -1, 0);
      idle(1); drain();
      chk("post_rst_rows", 65'(rx_cnt - rx0), 65'd1);

      // Random frames, some back-to-back, random consumer stalls.
      rnd_ready = 1;
      for (int f = 0; f < 12; f++) begin
         send_frame($urandom % 16, ($urandom % 3 == 0) ? $urandom % 64 : $urandom % 12, -1, 0);
         if ($urandom % 2) idle(1 + $urandom % 3);
      end
      idle(1);
      rnd_ready = 0;
      drain();
      chk("final_ovf", 65'(bus.ovf), 65'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
